pkt_send_engine: RTL and testbench

PKT_SEND_ENGINE -- requirements
Module: pkt_send_engine

---
 rtl/pkt_send_if.sv | 30 +++
 rtl/pkt_send_engine.sv | 209 ++++++++++++++++++++
 tb/tb_pkt_send_engine.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_send_if.sv
// Command and switch-write bus between a packet source and the send engine.
interface pkt_send_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned WIDTH_SEL      = 2,
  parameter int unsigned WIDTH_PRIORITY = 3,
  parameter int unsigned WIDTH_LENGTH   = 10
);
  logic                      cmd_vld;
  logic                      cmd_rdy;
  logic [WIDTH_SEL-1:0]      cmd_dest;
  logic [WIDTH_PRIORITY-1:0] cmd_priority;
  logic [WIDTH_LENGTH-1:0]   cmd_length;
  logic [1:0]                cmd_mode;
  logic                      wr_sop;
  logic                      wr_eop;
  logic                      wr_vld;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic                      full;
  logic                      alm_ost_full;

  modport master (
    input  cmd_vld, cmd_dest, cmd_priority, cmd_length, cmd_mode, full, alm_ost_full,
    output cmd_rdy, wr_sop, wr_eop, wr_vld, wr_data
  );

  modport slave (
    output cmd_vld, cmd_dest, cmd_priority, cmd_length, cmd_mode, full, alm_ost_full,
    input  cmd_rdy, wr_sop, wr_eop, wr_vld, wr_data
  );
endinterface

// File: rtl/pkt_send_engine.sv
// Queues packet commands and streams header + generated payload beats to a switch write port.
module pkt_send_engine #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned PORT_NUB_TOTAL  = 4,
  parameter int unsigned PRIORITY        = 8,
  parameter int unsigned DATA_LENGTH_MAX = 1024,
  parameter int unsigned CMD_DEPTH       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  pkt_send_if.master        bus,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pkt_cnt
);
  localparam int unsigned WS    = $clog2(PORT_NUB_TOTAL);
  localparam int unsigned WP    = $clog2(PRIORITY);
  localparam int unsigned WL    = $clog2(DATA_LENGTH_MAX);
  localparam int unsigned PTR_W = $clog2(CMD_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned REP   = (DATA_WIDTH + 31) / 32;

  typedef struct packed {
    logic [1:0]    mode;
    logic [WL-1:0] length;
    logic [WP-1:0] prio;
    logic [WS-1:0] dest;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] header_beat(input cmd_t c, input logic [15:0] s);
    return DATA_WIDTH'({s, c.length, c.prio, c.dest});
  endfunction

  function automatic logic [DATA_WIDTH-1:0] payload_beat(input logic [1:0] m, input logic [WL-1:0] i,
                                                         input logic [15:0] s, input logic [31:0] l);
    logic [REP*32-1:0] rep;
    rep = {REP{l}};
    case (m)
      2'b01:   return rep[DATA_WIDTH-1:0];
      2'b10:   return DATA_WIDTH'({s, i});
      default: return DATA_WIDTH'(i);
    endcase
  endfunction

  cmd_t                  fifo_mem [CMD_DEPTH];
  logic [PTR_W-1:0]      wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rdy_q, rdy_d;
  state_t                state_q, state_d;
  cmd_t                  cur_q, cur_d, head_cmd;
  logic [15:0]           seq_q, seq_d, pkt_q, pkt_d;
  logic [WL-1:0]         idx_q, idx_d, nxt_idx;
  logic [31:0]           lfsr_q, lfsr_d;
  logic                  sop_q, sop_d, eop_q, eop_d, vld_q, vld_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d, busy_q, busy_d;
  logic                  push, pop, xfer, can_start, nxt_last, do_payload, do_finish;

  // Command storage; entries need no reset since occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wp_q] <= cmd_t'({bus.cmd_mode, bus.cmd_length, bus.cmd_priority, bus.cmd_dest});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      cur_q   <= '0;
      seq_q   <= '0;
      pkt_q   <= '0;
      idx_q   <= '0;
      lfsr_q  <= 32'h1;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      cur_q   <= cur_d;
      seq_q   <= seq_d;
      pkt_q   <= pkt_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    seq_d      = seq_q;
    pkt_d      = pkt_q;
    idx_d      = idx_q;
    lfsr_d     = lfsr_q;
    sop_d      = sop_q;
    eop_d      = eop_q;
    vld_d      = vld_q;
    data_d     = data_q;
    done_d     = 1'b0;
    pop        = 1'b0;
    do_payload = 1'b0;
    do_finish  = 1'b0;
    push       = bus.cmd_vld && rdy_q;
    xfer       = vld_q && !bus.full;
    head_cmd   = fifo_mem[rp_q];
    can_start  = (cnt_q != '0) && !bus.alm_ost_full;
    nxt_idx    = (state_q == HEAD) ? '0 : idx_q + WL'(1);
    nxt_last   = ({1'b0, nxt_idx} + (WL+1)'(1)) == {1'b0, cur_q.length};

    case (state_q)
      IDLE: begin
        vld_d = 1'b0;
        sop_d = 1'b0;
        eop_d = 1'b0;
        if (can_start) begin
          pop     = 1'b1;
          cur_d   = head_cmd;
          state_d = HEAD;
        end
      end
      HEAD: begin
        // Header is presented the cycle after a pop from IDLE.
        if (!vld_q) begin
          vld_d  = 1'b1;
          sop_d  = 1'b1;
          eop_d  = (cur_q.length == '0);
          data_d = header_beat(cur_q, seq_q);
        end else if (xfer) begin
          if (cur_q.length == '0) do_finish  = 1'b1;
          else                    do_payload = 1'b1;
        end
      end
      BODY: begin
        if (xfer) begin
          if (eop_q) do_finish  = 1'b1;
          else       do_payload = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_payload) begin
      state_d = BODY;
      idx_d   = nxt_idx;
      vld_d   = 1'b1;
      sop_d   = 1'b0;
      eop_d   = nxt_last;
      data_d  = payload_beat(cur_q.mode, nxt_idx, seq_q, lfsr_q);
      if (cur_q.mode == 2'b01) lfsr_d = lfsr_next(lfsr_q);
    end

    // Eop transferred: chain straight into the next header when allowed.
    if (do_finish) begin
      seq_d  = seq_q + 16'd1;
      pkt_d  = pkt_q + 16'd1;
      done_d = 1'b1;
      if (can_start) begin
        pop     = 1'b1;
        cur_d   = head_cmd;
        state_d = HEAD;
        vld_d   = 1'b1;
        sop_d   = 1'b1;
        eop_d   = (head_cmd.length == '0);
        data_d  = header_beat(head_cmd, seq_d);
      end else begin
        state_d = IDLE;
        vld_d   = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        data_d  = '0;
      end
    end

    wp_d   = push ? wp_q + PTR_W'(1) : wp_q;
    rp_d   = pop  ? rp_q + PTR_W'(1) : rp_q;
    cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
    rdy_d  = (cnt_d != CNT_W'(CMD_DEPTH));
    busy_d = (cnt_d != '0) || (state_d != IDLE);
  end

  assign bus.cmd_rdy = rdy_q;
  assign bus.wr_sop  = sop_q;
  assign bus.wr_eop  = eop_q;
  assign bus.wr_vld  = vld_q;
  assign bus.wr_data = data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pkt_cnt     = pkt_q;
endmodule

// File: tb/tb_pkt_send_engine.sv
// Directed and random checks of pkt_send_engine against a packet-level beat scoreboard.
module tb_pkt_send_engine;
  localparam int unsigned DW = 32;
  localparam int unsigned WS = 2;
  localparam int unsigned WP = 3;
  localparam int unsigned WL = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy, done;
  logic [15:0] pkt_cnt;

  pkt_send_if #(.DATA_WIDTH(DW), .WIDTH_SEL(WS), .WIDTH_PRIORITY(WP), .WIDTH_LENGTH(WL)) bus_if ();

  pkt_send_engine #(.DATA_WIDTH(32), .PORT_NUB_TOTAL(4), .PRIORITY(8),
                    .DATA_LENGTH_MAX(1024), .CMD_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if), .busy(busy), .done(done), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: each accepted command expands into its full beat list.
  logic [DW+1:0] exp_q [$];
  int unsigned   m_seq, m_pkts;
  logic [31:0]   m_lfsr;
  bit            eop_pend;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    logic [31:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ ((32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1);
    return y;
  endfunction

  task expand(input int unsigned dest, input int unsigned prio, input int unsigned len, input int unsigned mode);
    logic [31:0] d;
    d = 32'((m_seq << 15) | (len << 5) | (prio << 2) | dest);
    exp_q.push_back({1'b1, len == 0, d});
    for (int unsigned i = 0; i < len; i++) begin
      if (mode == 1) begin
        d = m_lfsr;
        m_lfsr = lfsr_step(m_lfsr);
      end else if (mode == 2) begin
        d = 32'((m_seq << 10) | i);
      end else begin
        d = 32'(i);
      end
      exp_q.push_back({1'b0, i == len - 1, d});
    end
    m_seq = (m_seq + 1) % 65536;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_seq = 0; m_pkts = 0; m_lfsr = 32'h1; eop_pend = 0;
    end else begin
      if (eop_pend) m_pkts++;
      check("done_pulse", 64'(done), 64'(eop_pend));
      check("pkt_cnt", 64'(pkt_cnt), 64'(m_pkts[15:0]));
      eop_pend = 0;
      if (!bus_if.wr_vld) check("idle_framing", 64'({bus_if.wr_sop, bus_if.wr_eop}), 64'(0));
      if (bus_if.wr_vld && !bus_if.full) begin
        check("beat_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          check("beat", 64'({bus_if.wr_sop, bus_if.wr_eop, bus_if.wr_data}), 64'(exp_q.pop_front()));
          if (bus_if.wr_eop) eop_pend = 1;
        end
      end
      if (bus_if.cmd_vld && bus_if.cmd_rdy)
        expand(bus_if.cmd_dest, bus_if.cmd_priority, bus_if.cmd_length, bus_if.cmd_mode);
    end
  end

  task automatic send_cmd(input int unsigned dest, input int unsigned prio, input int unsigned len,
                          input int unsigned mode);
    bit ok = 0;
    bus_if.cmd_dest     = WS'(dest);
    bus_if.cmd_priority = WP'(prio);
    bus_if.cmd_length   = WL'(len);
    bus_if.cmd_mode     = 2'(mode);
    bus_if.cmd_vld      = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus_if.cmd_rdy;
    end
    check("cmd_accept", 64'(ok), 64'(1));
    @(posedge clk); #1;
    bus_if.cmd_vld = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      ok = !busy && exp_q.size() == 0 && !bus_if.wr_vld;
    end
    check("idle_reached", 64'(ok), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic wait_beat(input logic sop, input logic [31:0] data, output bit found);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      found = bus_if.wr_vld && bus_if.wr_sop == sop && bus_if.wr_data == data;
    end
  endtask

  initial begin
    bit found, acc, saw;
    int cnt, sent, cyc;
    bus_if.cmd_vld = 0; bus_if.cmd_dest = '0; bus_if.cmd_priority = '0;
    bus_if.cmd_length = '0; bus_if.cmd_mode = '0; bus_if.full = 0; bus_if.alm_ost_full = 0;

    #1;
    check("rst_flags", 64'({bus_if.wr_vld, bus_if.wr_sop, bus_if.wr_eop, bus_if.cmd_rdy, busy, done}), 64'(0));
    check("rst_data", 64'(bus_if.wr_data), 64'(0));
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
    repeat (2) @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    check("rdy_after_reset", 64'(bus_if.cmd_rdy), 64'(1));

    // Latency: header appears two edges after acceptance; data 0..9 follows.
    send_cmd(1, 1, 10, 0);
    @(negedge clk);
    check("lat_edge0", 64'(bus_if.wr_vld), 64'(0));
    @(negedge clk);
    check("lat_edge1", 64'(bus_if.wr_vld), 64'(0));
    @(negedge clk);
    check("lat_header", 64'({bus_if.wr_vld, bus_if.wr_sop, bus_if.wr_data}), 64'({2'b11, 32'h145}));
    wait_idle();
    check("pkt_cnt_one", 64'(pkt_cnt), 64'(1));

    // Zero-length packet.
    send_cmd(2, 5, 0, 1);
    wait_idle();

    // Four queued behind alm_ost_full, fifth refused, then contiguous burst.
    bus_if.alm_ost_full = 1;
    send_cmd(0, 1, 15, 0);
    send_cmd(1, 2, 20, 2);
    send_cmd(2, 3, 30, 1);
    send_cmd(3, 4, 5, 3);
    bus_if.cmd_vld = 1;
    @(negedge clk);
    check("fifo_full_rdy", 64'(bus_if.cmd_rdy), 64'(0));
    check("alm_blocks_start", 64'(bus_if.wr_vld), 64'(0));
    @(posedge clk); #1;
    bus_if.cmd_vld = 0;
    bus_if.alm_ost_full = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = bus_if.wr_vld;
    end
    cnt = 0;
    while (bus_if.wr_vld && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check("b2b_beats", 64'(cnt), 64'(74));
    wait_idle();

    // Stall on payload beat 4 for three cycles.
    send_cmd(0, 0, 10, 0);
    wait_beat(1'b0, 32'd4, found);
    check("stall_reach", 64'(found), 64'(1));
    bus_if.full = 1;
    repeat (3) begin
      @(negedge clk);
      check("stall_hold", 64'({bus_if.wr_vld, bus_if.wr_sop, bus_if.wr_eop, bus_if.wr_data}),
            64'({3'b100, 32'd4}));
    end
    @(posedge clk); #1;
    bus_if.full = 0;
    wait_idle();

    // alm_ost_full holds off a start but not an in-flight packet.
    bus_if.alm_ost_full = 1;
    send_cmd(3, 7, 6, 2);
    saw = 0;
    repeat (8) begin
      @(negedge clk);
      saw |= bus_if.wr_vld;
    end
    check("alm_hold_off", 64'(saw), 64'(0));
    @(posedge clk); #1;
    bus_if.alm_ost_full = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      found = bus_if.wr_vld;
    end
    check("alm_release_start", 64'(found), 64'(1));
    bus_if.alm_ost_full = 1;
    wait_idle();
    bus_if.alm_ost_full = 0;

    // Reset at payload beat 7 aborts the packet; LFSR and seq restart.
    send_cmd(1, 2, 10, 0);
    wait_beat(1'b0, 32'd7, found);
    check("reset_reach", 64'(found), 64'(1));
    rst_n = 0;
    #1;
    check("rst_abort_flags", 64'({bus_if.wr_vld, bus_if.wr_sop, bus_if.wr_eop, busy, done, bus_if.cmd_rdy}), 64'(0));
    check("rst_abort_cnt", 64'(pkt_cnt), 64'(0));
    repeat (2) @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    send_cmd(0, 1, 4, 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = bus_if.wr_vld;
    end
    check("post_rst_header", 64'({bus_if.wr_sop, bus_if.wr_data}), 64'({1'b1, 32'h84}));
    @(negedge clk);
    check("post_rst_lfsr", 64'(bus_if.wr_data), 64'(32'h1));
    wait_idle();

    // Random commands with random backpressure.
    sent = 0; cyc = 0;
    while ((sent < 40 || bus_if.cmd_vld) && cyc < 20000) begin
      @(negedge clk);
      acc = bus_if.cmd_vld && bus_if.cmd_rdy;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        bus_if.cmd_vld = 0;
        sent++;
      end
      bus_if.full = ($urandom_range(0, 3) == 0);
      bus_if.alm_ost_full = ($urandom_range(0, 5) == 0);
      if (!bus_if.cmd_vld && sent < 40 && $urandom_range(0, 2) != 0) begin
        bus_if.cmd_dest     = WS'($urandom_range(0, 3));
        bus_if.cmd_priority = WP'($urandom_range(0, 7));
        bus_if.cmd_length   = WL'($urandom_range(0, 40));
        bus_if.cmd_mode     = 2'($urandom_range(0, 3));
        bus_if.cmd_vld      = 1;
      end
    end
    check("random_sent", 64'(sent), 64'(40));
    bus_if.full = 0;
    bus_if.alm_ost_full = 0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
